// File: rtl/fp_divider_param_if.sv
// Strobe-handshake bundle for the parametrised FP divider.
//   a_value_i/b_value_i : dividend/divisor {sign, exp, frac}
//   rm_i                : rounding mode (RNE/RTZ/RDN/RUP/RMM)
//   exec_strobe_i       : start request, honoured while busy_o is low
//   busy_o              : operation in flight
//   z_value_o/flags_o   : result and {NV, DZ, OF, UF, NX}
//   done_strobe_o       : one-cycle completion pulse
interface fp_divider_param_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned FW = 1 + EXP_W + MAN_W;

   logic [FW-1:0] a_value_i;
   logic [FW-1:0] b_value_i;
   logic [2:0]    rm_i;
   logic          exec_strobe_i;
   logic          busy_o;
   logic [FW-1:0] z_value_o;
   logic [4:0]    flags_o;
   logic          done_strobe_o;

   modport master (
      output a_value_i, b_value_i, rm_i, exec_strobe_i,
      input  busy_o, z_value_o, flags_o, done_strobe_o
   );

   modport slave (
      input  a_value_i, b_value_i, rm_i, exec_strobe_i,
      output busy_o, z_value_o, flags_o, done_strobe_o
   );
endinterface

// File: rtl/fp_divider_param.sv
// Iterative IEEE-754 divider, any exponent/fraction width, one quotient bit
// per cycle (restoring), with dynamic rounding, exception flags and
// canonical qNaN.
//   clk      : clock
//   reset_ni : asynchronous active-low reset
//   io       : slave side of fp_divider_param_if (operands, rm, strobes, result)
module fp_divider_param #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic              clk,
   input logic              reset_ni,
   fp_divider_param_if.slave io
);
   localparam int unsigned FW = 1 + EXP_W + MAN_W;
   localparam int unsigned M  = MAN_W + 1;
   localparam int unsigned NQ = MAN_W + 4;
   localparam int unsigned EW = EXP_W + 2;
   localparam int unsigned CW = $clog2(NQ + 1);
   localparam logic signed [EW-1:0] ONE  = EW'(1);
   localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMIN = ONE - BIAS;
   localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE, S_SPECIAL, S_NORM_A, S_NORM_B, S_DIVIDE,
      S_NORM_Z, S_ROUND, S_PACK, S_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [FW-1:0]          a_raw_q, a_raw_d, b_raw_q, b_raw_d, z_q, z_d;
   logic [2:0]             rm_q, rm_d;
   logic                   sign_q, sign_d;
   logic signed [EW-1:0]   a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
   logic [M-1:0]           a_m_q, a_m_d, b_m_q, b_m_d;
   logic [NQ-1:0]          z_m_q, z_m_d;
   logic [M:0]             rem_q, rem_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   sticky_q, sticky_d, tiny_q, tiny_d, nx_q, nx_d;
   logic                   nz_shift_q, nz_shift_d, busy_q, busy_d, done_q, done_d;
   logic [4:0]             flags_q, flags_d;

   // Operand classification, valid in SPECIAL from the captured raw words
   logic [EXP_W-1:0] a_ef, b_ef;
   logic             a_ez, b_ez, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic             a_snan, b_snan;
   assign a_ef   = a_raw_q[FW-2 -: EXP_W];
   assign b_ef   = b_raw_q[FW-2 -: EXP_W];
   assign a_ez   = ~|a_ef;
   assign b_ez   = ~|b_ef;
   assign a_nan  = (&a_ef) & (|a_raw_q[MAN_W-1:0]);
   assign b_nan  = (&b_ef) & (|b_raw_q[MAN_W-1:0]);
   assign a_inf  = (&a_ef) & ~(|a_raw_q[MAN_W-1:0]);
   assign b_inf  = (&b_ef) & ~(|b_raw_q[MAN_W-1:0]);
   assign a_zero = a_ez & ~(|a_raw_q[MAN_W-1:0]);
   assign b_zero = b_ez & ~(|b_raw_q[MAN_W-1:0]);
   assign a_snan = a_nan & ~a_raw_q[MAN_W-1];
   assign b_snan = b_nan & ~b_raw_q[MAN_W-1];

   // Restoring division step
   logic       qbit;
   logic [M:0] rem_nxt;
   assign qbit    = (rem_q >= {1'b0, b_m_q});
   assign rem_nxt = qbit ? (rem_q - {1'b0, b_m_q}) : rem_q;

   // Quotient normalisation helpers
   logic signed [EW-1:0] nz_e, z_e_inc;
   logic [NQ-1:0]        nz_m;
   assign nz_e    = z_m_q[NQ-1] ? z_e_q : (z_e_q - ONE);
   assign nz_m    = z_m_q[NQ-1] ? z_m_q : (z_m_q << 1);
   assign z_e_inc = z_e_q + ONE;

   // Rounding: z_m holds {hidden, fraction, guard, round, sticky-bit}
   logic [M-1:0] kept;
   logic [M:0]   sum;
   logic         grd, rnd, stk, inexact, rnd_up, to_max;
   assign kept    = z_m_q[NQ-1:3];
   assign grd     = z_m_q[2];
   assign rnd     = z_m_q[1];
   assign stk     = z_m_q[0] | sticky_q;
   assign inexact = grd | rnd | stk;
   assign sum     = {1'b0, kept} + (M+1)'(rnd_up);
   assign to_max  = (rm_q == 3'd1) | ((rm_q == 3'd2) & ~sign_q) | ((rm_q == 3'd3) & sign_q);

   always_comb begin
      rnd_up = 1'b0;
      case (rm_q)
         3'd1:    rnd_up = 1'b0;
         3'd2:    rnd_up = sign_q & inexact;
         3'd3:    rnd_up = ~sign_q & inexact;
         3'd4:    rnd_up = grd;
         default: rnd_up = grd & (rnd | stk | kept[0]);
      endcase
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      a_raw_d    = a_raw_q;
      b_raw_d    = b_raw_q;
      rm_d       = rm_q;
      sign_d     = sign_q;
      a_e_d      = a_e_q;
      b_e_d      = b_e_q;
      a_m_d      = a_m_q;
      b_m_d      = b_m_q;
      z_e_d      = z_e_q;
      z_m_d      = z_m_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      sticky_d   = sticky_q;
      tiny_d     = tiny_q;
      nx_d       = nx_q;
      nz_shift_d = nz_shift_q;
      z_d        = z_q;
      flags_d    = flags_q;
      unique case (state_q)
         S_IDLE: if (io.exec_strobe_i) begin
            a_raw_d = io.a_value_i;
            b_raw_d = io.b_value_i;
            rm_d    = (io.rm_i > 3'd4) ? 3'd0 : io.rm_i;
            state_d = S_SPECIAL;
         end
         S_SPECIAL: begin
            sign_d  = a_raw_q[FW-1] ^ b_raw_q[FW-1];
            state_d = S_DONE;
            if (a_nan | b_nan) begin
               z_d = QNAN;  flags_d = {a_snan | b_snan, 4'b0000};
            end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
               z_d = QNAN;  flags_d = 5'b10000;
            end else if (a_inf) begin
               z_d = {sign_d, {EXP_W{1'b1}}, MAN_W'(0)};  flags_d = 5'b00000;
            end else if (b_inf | a_zero) begin
               z_d = {sign_d, EXP_W'(0), MAN_W'(0)};      flags_d = 5'b00000;
            end else if (b_zero) begin
               z_d = {sign_d, {EXP_W{1'b1}}, MAN_W'(0)};  flags_d = 5'b01000;
            end else begin
               a_e_d   = a_ez ? EMIN : (EW'(a_ef) - BIAS);
               b_e_d   = b_ez ? EMIN : (EW'(b_ef) - BIAS);
               a_m_d   = {~a_ez, a_raw_q[MAN_W-1:0]};
               b_m_d   = {~b_ez, b_raw_q[MAN_W-1:0]};
               state_d = S_NORM_A;
            end
         end
         S_NORM_A: if (a_m_q[M-1]) state_d = S_NORM_B;
                   else begin a_m_d = a_m_q << 1; a_e_d = a_e_q - ONE; end
         S_NORM_B: if (b_m_q[M-1]) begin
                      rem_d      = {1'b0, a_m_q};
                      z_e_d      = a_e_q - b_e_q;
                      z_m_d      = '0;
                      cnt_d      = '0;
                      nz_shift_d = 1'b0;
                      state_d    = S_DIVIDE;
                   end else begin b_m_d = b_m_q << 1; b_e_d = b_e_q - ONE; end
         S_DIVIDE: begin
            z_m_d = {z_m_q[NQ-2:0], qbit};
            rem_d = {rem_nxt[M-1:0], 1'b0};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NQ - 1)) begin
               sticky_d = |rem_nxt;
               state_d  = S_NORM_Z;
            end
         end
         S_NORM_Z: if (!nz_shift_q) begin
            // First visit: fix a quotient below 1.0, then decide on denormalising
            z_m_d      = nz_m;
            z_e_d      = nz_e;
            tiny_d     = (nz_e < EMIN);
            nz_shift_d = 1'b1;
            state_d    = (nz_e < EMIN) ? S_NORM_Z : S_ROUND;
         end else begin
            z_m_d    = z_m_q >> 1;
            sticky_d = sticky_q | z_m_q[0];
            z_e_d    = z_e_inc;
            if (z_e_inc >= EMIN) state_d = S_ROUND;
         end
         S_ROUND: begin
            nx_d = inexact;
            if (sum[M]) begin
               z_m_d = {sum[M:1], 3'b000};
               z_e_d = z_e_inc;
            end else begin
               z_m_d = {sum[M-1:0], 3'b000};
            end
            state_d = S_PACK;
         end
         S_PACK: begin
            if (z_e_q > BIAS) begin
               z_d = to_max ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                            : {sign_q, {EXP_W{1'b1}}, MAN_W'(0)};
               flags_d = 5'b00101;
            end else begin
               // Hidden bit clear means subnormal (or zero): exponent field 0
               z_d = {sign_q, z_m_q[NQ-1] ? EXP_W'(z_e_q + BIAS) : EXP_W'(0), z_m_q[NQ-2:3]};
               flags_d = {3'b000, tiny_q & nx_q, nx_q};
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_q == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         a_raw_q    <= '0;
         b_raw_q    <= '0;
         rm_q       <= '0;
         sign_q     <= 1'b0;
         a_e_q      <= '0;
         b_e_q      <= '0;
         a_m_q      <= '0;
         b_m_q      <= '0;
         z_e_q      <= '0;
         z_m_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         sticky_q   <= 1'b0;
         tiny_q     <= 1'b0;
         nx_q       <= 1'b0;
         nz_shift_q <= 1'b0;
         z_q        <= '0;
         flags_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_raw_q    <= a_raw_d;
         b_raw_q    <= b_raw_d;
         rm_q       <= rm_d;
         sign_q     <= sign_d;
         a_e_q      <= a_e_d;
         b_e_q      <= b_e_d;
         a_m_q      <= a_m_d;
         b_m_q      <= b_m_d;
         z_e_q      <= z_e_d;
         z_m_q      <= z_m_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         sticky_q   <= sticky_d;
         tiny_q     <= tiny_d;
         nx_q       <= nx_d;
         nz_shift_q <= nz_shift_d;
         z_q        <= z_d;
         flags_q    <= flags_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign io.busy_o        = busy_q;
   assign io.done_strobe_o = done_q;
   assign io.z_value_o     = z_q;
   assign io.flags_o       = flags_q;
endmodule

// File: tb/tb_fp_divider_param.sv
// Directed bench for fp_divider_param: float32 and half-precision instances
// sharing clock and reset; results, flags and strobe latency are compared
// against hand-computed values.
module tb_fp_divider_param;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp_divider_param_if #(.EXP_W(8), .MAN_W(23)) s_if ();
   fp_divider_param_if #(.EXP_W(5), .MAN_W(10)) h_if ();

   fp_divider_param #(.EXP_W(8), .MAN_W(23)) u_s (.clk(clk), .reset_ni(rst_n), .io(s_if.slave));
   fp_divider_param #(.EXP_W(5), .MAN_W(10)) u_h (.clk(clk), .reset_ni(rst_n), .io(h_if.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts an op from just after a rising edge; returns at the strobe cycle
   task automatic run_s(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                        output logic [31:0] z, output logic [4:0] fl, output int lat,
                        output bit busy_ok);
      s_if.a_value_i = a; s_if.b_value_i = b; s_if.rm_i = rm; s_if.exec_strobe_i = 1'b1;
      lat = 0; busy_ok = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (i == 1) begin
            s_if.exec_strobe_i = 1'b0;
            s_if.a_value_i = ~a; s_if.b_value_i = ~b; s_if.rm_i = 3'd3;
         end
         if (s_if.done_strobe_o) begin lat = i; break; end
         if (!s_if.busy_o) busy_ok = 1'b0;
      end
      if (s_if.busy_o) busy_ok = 1'b0;
      z = s_if.z_value_o; fl = s_if.flags_o;
   endtask

   task automatic run_h(input logic [15:0] a, input logic [15:0] b, input logic [2:0] rm,
                        output logic [15:0] z, output logic [4:0] fl, output int lat);
      h_if.a_value_i = a; h_if.b_value_i = b; h_if.rm_i = rm; h_if.exec_strobe_i = 1'b1;
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk); #1;
         if (i == 1) h_if.exec_strobe_i = 1'b0;
         if (h_if.done_strobe_o) begin lat = i; break; end
      end
      z = h_if.z_value_o; fl = h_if.flags_o;
   endtask

   initial begin
      logic [31:0] z;
      logic [15:0] zh;
      logic [4:0]  fl;
      int          lat, nstrobe;
      bit          bok;

      rst_n = 1'b0;
      s_if.a_value_i = '0; s_if.b_value_i = '0; s_if.rm_i = '0; s_if.exec_strobe_i = 1'b0;
      h_if.a_value_i = '0; h_if.b_value_i = '0; h_if.rm_i = '0; h_if.exec_strobe_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_z",     64'(s_if.z_value_o),     64'h0);
      chk("rst_flags", 64'(s_if.flags_o),       64'h0);
      chk("rst_busy",  64'(s_if.busy_o),        64'h0);
      chk("rst_done",  64'(s_if.done_strobe_o), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 6.0 / 2.0 with exact latency and busy window
      run_s(32'h40C00000, 32'h40000000, 3'd0, z, fl, lat, bok);
      chk("six_by_two_z", 64'(z), 64'h40400000);
      chk("six_by_two_fl", 64'(fl), 64'h0);
      chk("six_by_two_lat", 64'(lat), 64'd35);
      chk("six_by_two_busy", 64'(bok), 64'd1);

      // 1/3 under each rounding mode; NX only
      run_s(32'h3F800000, 32'h40400000, 3'd0, z, fl, lat, bok);
      chk("third_rne_z", 64'(z), 64'h3EAAAAAB);  chk("third_rne_fl", 64'(fl), 64'h01);
      run_s(32'h3F800000, 32'h40400000, 3'd1, z, fl, lat, bok);
      chk("third_rtz_z", 64'(z), 64'h3EAAAAAA);  chk("third_rtz_fl", 64'(fl), 64'h01);
      run_s(32'h3F800000, 32'h40400000, 3'd3, z, fl, lat, bok);
      chk("third_rup_z", 64'(z), 64'h3EAAAAAB);  chk("third_rup_fl", 64'(fl), 64'h01);
      run_s(32'hBF800000, 32'h40400000, 3'd2, z, fl, lat, bok);
      chk("third_rdn_z", 64'(z), 64'hBEAAAAAB);  chk("third_rdn_fl", 64'(fl), 64'h01);
      run_s(32'h3F800000, 32'h40400000, 3'd7, z, fl, lat, bok);
      chk("third_rm7_z", 64'(z), 64'h3EAAAAAB);

      // Special operands: {NV,DZ,OF,UF,NX}, strobe 3 cycles after accept
      run_s(32'h3F800000, 32'h00000000, 3'd0, z, fl, lat, bok);
      chk("div0_z", 64'(z), 64'h7F800000); chk("div0_fl", 64'(fl), 64'h08); chk("div0_lat", 64'(lat), 64'd3);
      run_s(32'h00000000, 32'h00000000, 3'd0, z, fl, lat, bok);
      chk("zz_z", 64'(z), 64'h7FC00000);   chk("zz_fl", 64'(fl), 64'h10);   chk("zz_lat", 64'(lat), 64'd3);
      run_s(32'h7F800000, 32'h7F800000, 3'd0, z, fl, lat, bok);
      chk("ii_z", 64'(z), 64'h7FC00000);   chk("ii_fl", 64'(fl), 64'h10);   chk("ii_lat", 64'(lat), 64'd3);
      run_s(32'h7F800001, 32'h3F800000, 3'd0, z, fl, lat, bok);
      chk("snan_z", 64'(z), 64'h7FC00000); chk("snan_fl", 64'(fl), 64'h10); chk("snan_lat", 64'(lat), 64'd3);
      run_s(32'h7FC00000, 32'h3F800000, 3'd0, z, fl, lat, bok);
      chk("qnan_z", 64'(z), 64'h7FC00000); chk("qnan_fl", 64'(fl), 64'h00); chk("qnan_lat", 64'(lat), 64'd3);
      run_s(32'hFF800000, 32'h40000000, 3'd0, z, fl, lat, bok);
      chk("ninf_z", 64'(z), 64'hFF800000); chk("ninf_fl", 64'(fl), 64'h00);

      // Overflow
      run_s(32'h7F7FFFFF, 32'h3F000000, 3'd0, z, fl, lat, bok);
      chk("ovf_rne_z", 64'(z), 64'h7F800000); chk("ovf_rne_fl", 64'(fl), 64'h05);
      run_s(32'h7F7FFFFF, 32'h3F000000, 3'd1, z, fl, lat, bok);
      chk("ovf_rtz_z", 64'(z), 64'h7F7FFFFF); chk("ovf_rtz_fl", 64'(fl), 64'h05);

      // Subnormal results and subnormal operands (extra normalisation cycles)
      run_s(32'h00800000, 32'h40000000, 3'd0, z, fl, lat, bok);
      chk("sub_half_z", 64'(z), 64'h00400000); chk("sub_half_fl", 64'(fl), 64'h00);
      chk("sub_half_lat", 64'(lat), 64'd36);
      run_s(32'h00000001, 32'h40000000, 3'd0, z, fl, lat, bok);
      chk("ulp_by2_z", 64'(z), 64'h00000000); chk("ulp_by2_fl", 64'(fl), 64'h03);
      chk("ulp_by2_lat", 64'(lat), 64'd82);
      run_s(32'h00000001, 32'h3F000000, 3'd0, z, fl, lat, bok);
      chk("ulp_x2_z", 64'(z), 64'h00000002);  chk("ulp_x2_fl", 64'(fl), 64'h00);
      chk("ulp_x2_lat", 64'(lat), 64'd80);

      // Back-to-back: exec in the strobe cycle of the previous op
      run_s(32'h3F800000, 32'h00000000, 3'd0, z, fl, lat, bok);
      chk("b2b_z", 64'(z), 64'h7F800000); chk("b2b_lat", 64'(lat), 64'd3);

      // exec while busy is ignored: exactly one strobe with the first result
      @(posedge clk); #1;
      s_if.a_value_i = 32'h40C00000; s_if.b_value_i = 32'h40000000; s_if.rm_i = 3'd0;
      s_if.exec_strobe_i = 1'b1;
      nstrobe = 0; lat = 0; z = '0;
      for (int i = 1; i <= 90; i++) begin
         @(posedge clk); #1;
         s_if.exec_strobe_i = (i == 5);
         if (i == 5) begin s_if.a_value_i = 32'h3F800000; s_if.b_value_i = 32'h0; end
         if (s_if.done_strobe_o) begin
            nstrobe++;
            if (nstrobe == 1) begin lat = i; z = s_if.z_value_o; end
         end
      end
      chk("ign_strobes", 64'(nstrobe), 64'd1);
      chk("ign_lat", 64'(lat), 64'd35);
      chk("ign_z", 64'(z), 64'h40400000);

      // Asynchronous reset mid-divide drops the operation
      s_if.a_value_i = 32'h3F800000; s_if.b_value_i = 32'h40400000; s_if.exec_strobe_i = 1'b1;
      @(posedge clk); #1;
      s_if.exec_strobe_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("amid_z",    64'(s_if.z_value_o), 64'h0);
      chk("amid_fl",   64'(s_if.flags_o),   64'h0);
      chk("amid_busy", 64'(s_if.busy_o),    64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      nstrobe = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (s_if.done_strobe_o) nstrobe++;
      end
      chk("amid_nostrobe", 64'(nstrobe), 64'd0);
      run_s(32'h40C00000, 32'h40000000, 3'd0, z, fl, lat, bok);
      chk("post_rst_z", 64'(z), 64'h40400000); chk("post_rst_lat", 64'(lat), 64'd35);

      // Half precision instance
      run_h(16'h3C00, 16'h4200, 3'd0, zh, fl, lat);
      chk("h_third_z", 64'(zh), 64'h3555); chk("h_third_fl", 64'(fl), 64'h01);
      chk("h_third_lat", 64'(lat), 64'd22);
      run_h(16'h7BFF, 16'h3800, 3'd0, zh, fl, lat);
      chk("h_ovf_z", 64'(zh), 64'h7C00);   chk("h_ovf_fl", 64'(fl), 64'h05);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
